// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and constants for the accumulator datapath
package cpu_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 16;

  // IorD select encoding, shared with the IorD mux and the control FSM
  localparam logic IORD_INST = 1'b0;
  localparam logic IORD_DATA = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } mau_state_e;

endpackage

// File: rtl/mem_wait_ctr.sv
// rtl/mem_wait_ctr.sv - clear/enable saturating wait counter with terminal count
module mem_wait_ctr #(
  parameter int TIMEOUT = 15,
  parameter int CTR_W   = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [CTR_W-1:0] MAX_VAL  = CTR_W'(TIMEOUT);
  localparam logic [CTR_W-1:0] LAST_VAL = CTR_W'(TIMEOUT - 1);

  logic [CTR_W-1:0] count_q;
  logic [CTR_W-1:0] count_d;

  // Clear has priority; increment saturates at TIMEOUT so the count never wraps
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != MAX_VAL)) begin
      count_d = count_q + 1'b1;
    end
  end

  // tc flags that one more enabled cycle brings the count to TIMEOUT
  assign tc = (count_q >= LAST_VAL);

  // Counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - memory-side sequencer steering reads into IR or MDR
module mem_access_unit
  import cpu_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int TIMEOUT = 15
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              start,
  input  logic              iord,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] ir,
  output logic [DATA_W-1:0] mdr,
  output logic              busy,
  output logic              done,
  output logic              err
);

  mau_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              iord_q, iord_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] mdr_q, mdr_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              ctr_clr, ctr_en, ctr_tc;

  mem_wait_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_ctr (
    .clk (CLK),
    .rst (Reset),
    .clr (ctr_clr),
    .en  (ctr_en),
    .tc  (ctr_tc)
  );

  // Next-state and register updates; done_d mirrors entry into DONE so done is registered
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    iord_d  = iord_q;
    we_d    = we_q;
    ir_d    = ir_q;
    mdr_d   = mdr_q;
    done_d  = 1'b0;
    err_d   = err_q;
    ctr_clr = 1'b0;
    ctr_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if ((iord == IORD_INST) && we) begin
            // Writing into the instruction side is refused without touching memory
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            addr_d  = addr;
            wdata_d = wdata;
            iord_d  = iord;
            we_d    = we;
            ctr_clr = 1'b1;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (mem_ack) begin
          // An ack in the final wait cycle still wins over the timeout
          if (!we_q) begin
            if (iord_q == IORD_INST) begin
              ir_d = mem_rdata;
            end else begin
              mdr_d = mem_rdata;
            end
          end
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          ctr_en = 1'b1;
          if (ctr_tc) begin
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops the request immediately
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      iord_q  <= 1'b0;
      we_q    <= 1'b0;
      ir_q    <= '0;
      mdr_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      iord_q  <= iord_d;
      we_q    <= we_d;
      ir_q    <= ir_d;
      mdr_q   <= mdr_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign mem_req   = (state_q == REQ);
  assign mem_we    = mem_req && we_q;
  assign busy      = (state_q != IDLE);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign ir        = ir_q;
  assign mdr       = mdr_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit
module tb_mem_access_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic        iord;
  logic        we;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic [15:0] ir;
  logic [15:0] mdr;
  logic        busy;
  logic        done;
  logic        err;

  int total;
  int bad;
  int n_req;
  int n_done;

  mem_access_unit #(
    .DATA_W  (16),
    .ADDR_W  (16),
    .TIMEOUT (15)
  ) dut (
    .CLK       (clk),
    .Reset     (rst),
    .start     (start),
    .iord      (iord),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .ir        (ir),
    .mdr       (mdr),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the next negedge with the start consumed
  task automatic start_op(input logic i_iord, input logic i_we,
                          input logic [15:0] i_addr, input logic [15:0] i_wdata);
    start = 1'b1;
    iord  = i_iord;
    we    = i_we;
    addr  = i_addr;
    wdata = i_wdata;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    start = 1'b0;
    iord = 1'b0;
    we = 1'b0;
    addr = '0;
    wdata = '0;
    mem_ack = 1'b0;
    mem_rdata = '0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_mem_req", mem_req, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_ir", ir, 0);
    check("rst_mdr", mdr, 0);
    check("rst_mem_addr", mem_addr, 0);
    rst = 1'b0;
    @(negedge clk);

    // Fetch, ack in the first REQ cycle
    start_op(1'b0, 1'b0, 16'h0010, 16'h0000);
    check("fetch_req", mem_req, 1);
    check("fetch_busy", busy, 1);
    check("fetch_we", mem_we, 0);
    check("fetch_addr", mem_addr, 16'h0010);
    mem_ack = 1'b1;
    mem_rdata = 16'hA5C3;
    @(negedge clk);
    mem_ack = 1'b0;
    check("fetch_done", done, 1);
    check("fetch_req_off", mem_req, 0);
    check("fetch_ir", ir, 16'hA5C3);
    check("fetch_mdr", mdr, 0);
    check("fetch_err", err, 0);
    @(negedge clk);
    check("fetch_done_once", done, 0);
    check("fetch_idle", busy, 0);

    // Data read, ack in the fifth REQ cycle, with a stray start mid-REQ
    start_op(1'b1, 1'b0, 16'h8001, 16'h0000);
    n_req = 0;
    for (int i = 1; i <= 5; i++) begin
      if (mem_req) n_req++;
      if (i == 2) begin
        start = 1'b1;
        addr = 16'h5555;
      end
      if (i == 3) begin
        start = 1'b0;
        check("ignored_start_addr", mem_addr, 16'h8001);
      end
      if (i == 5) begin
        mem_ack = 1'b1;
        mem_rdata = 16'h1234;
      end
      @(negedge clk);
    end
    mem_ack = 1'b0;
    check("rd_req_cycles", n_req, 5);
    check("rd_req_off", mem_req, 0);
    check("rd_done", done, 1);
    check("rd_mdr", mdr, 16'h1234);
    check("rd_ir_kept", ir, 16'hA5C3);
    check("rd_addr_kept", mem_addr, 16'h8001);
    @(negedge clk);
    check("rd_done_once", done, 0);

    // Store
    start_op(1'b1, 1'b1, 16'h00FF, 16'hBEEF);
    check("st_req", mem_req, 1);
    check("st_we", mem_we, 1);
    check("st_wdata", mem_wdata, 16'hBEEF);
    check("st_addr", mem_addr, 16'h00FF);
    mem_ack = 1'b1;
    mem_rdata = 16'hFFFF;
    @(negedge clk);
    mem_ack = 1'b0;
    check("st_done", done, 1);
    check("st_we_off", mem_we, 0);
    check("st_ir_kept", ir, 16'hA5C3);
    check("st_mdr_kept", mdr, 16'h1234);
    check("st_err", err, 0);
    @(negedge clk);

    // Timeout, started back-to-back in the cycle after done
    start_op(1'b1, 1'b0, 16'h0200, 16'h0000);
    n_req = 0;
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      if (mem_req) n_req++;
      if (done) n_done++;
      @(negedge clk);
    end
    check("to_req_cycles", n_req, 15);
    check("to_done_pulses", n_done, 1);
    check("to_err", err, 1);
    check("to_ir_kept", ir, 16'hA5C3);
    check("to_mdr_kept", mdr, 16'h1234);

    // A good fetch afterwards leaves err set
    start_op(1'b0, 1'b0, 16'h0020, 16'h0000);
    mem_ack = 1'b1;
    mem_rdata = 16'h0F0F;
    @(negedge clk);
    mem_ack = 1'b0;
    check("sticky_done", done, 1);
    check("sticky_ir", ir, 16'h0F0F);
    check("sticky_err", err, 1);
    @(negedge clk);

    // Asynchronous reset mid-REQ
    start_op(1'b1, 1'b0, 16'h0300, 16'h0000);
    check("ar_req_before", mem_req, 1);
    #2;
    rst = 1'b1;
    #1;
    check("ar_req", mem_req, 0);
    check("ar_busy", busy, 0);
    check("ar_done", done, 0);
    check("ar_err", err, 0);
    check("ar_ir", ir, 0);
    check("ar_mdr", mdr, 0);
    check("ar_addr", mem_addr, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Fresh fetch after reset
    start_op(1'b0, 1'b0, 16'h0044, 16'h0000);
    check("pr_req", mem_req, 1);
    check("pr_addr", mem_addr, 16'h0044);
    mem_ack = 1'b1;
    mem_rdata = 16'h7777;
    @(negedge clk);
    mem_ack = 1'b0;
    check("pr_done", done, 1);
    check("pr_ir", ir, 16'h7777);
    check("pr_err", err, 0);
    @(negedge clk);

    // Illegal instruction-side write
    start_op(1'b0, 1'b1, 16'h0033, 16'h9999);
    check("ill_req", mem_req, 0);
    check("ill_done", done, 1);
    check("ill_err", err, 1);
    check("ill_busy", busy, 1);
    check("ill_addr_kept", mem_addr, 16'h0044);
    @(negedge clk);
    check("ill_req_after", mem_req, 0);
    check("ill_done_once", done, 0);
    check("ill_idle", busy, 0);
    check("ill_ir_kept", ir, 16'h7777);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
